// File: rtl/prv32_pkg.sv
// Shared definitions for the prv32 execute-stage branch logic:
// branch funct3 encodings and the branch-resolve FSM states.
package prv32_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

endpackage

// File: rtl/prv32_br_cond.sv
// Combinational branch condition decoder: funct3 plus the SUB flags give taken/illegal.
// Kept separate so a future predictor-verify stage can reuse it.
module prv32_br_cond
  import prv32_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       cf_i,
  input  logic       zf_i,
  input  logic       vf_i,
  input  logic       sf_i,
  output logic       taken_o,
  output logic       illegal_o
);

  // cf follows the carry-out convention, so cf=1 means a>=b unsigned
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BR_BEQ:  taken_o = zf_i;
      BR_BNE:  taken_o = ~zf_i;
      BR_BLT:  taken_o = sf_i ^ vf_i;
      BR_BGE:  taken_o = ~(sf_i ^ vf_i);
      BR_BLTU: taken_o = ~cf_i;
      BR_BGEU: taken_o = cf_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/prv32_branch_resolve.sv
// Execute-stage branch/jump resolution: registered redirect, multi-cycle front-end
// flush and saturating branch statistics. Static prediction is not-taken.
module prv32_branch_resolve
  import prv32_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic             cf_i,
  input  logic             zf_i,
  input  logic             vf_i,
  input  logic             sf_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      alu_r_i,
  output logic             redirect_o,
  output logic [31:0]      target_o,
  output logic             flush_o,
  output logic             illegal_br_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  br_state_e   state, state_next;
  logic [2:0]  flush_cnt;
  logic        cond_taken, cond_illegal;
  logic        accept, br_acc, br_taken, take;
  logic [31:0] next_target;

  prv32_br_cond u_cond (
    .funct3_i  (funct3_i),
    .cf_i      (cf_i),
    .zf_i      (zf_i),
    .vf_i      (vf_i),
    .sf_i      (sf_i),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  // Inputs seen during a flush belong to squashed wrong-path instructions
  assign accept      = (br_valid_i | jal_i | jalr_i) & ~stall_i & (state == ST_IDLE);
  assign br_acc      = accept & br_valid_i;
  assign br_taken    = br_acc & cond_taken;
  assign take        = br_taken | (accept & (jal_i | jalr_i));
  assign next_target = jalr_i ? (alu_r_i & ~32'd1) : (pc_i + imm_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (take) state_next = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == 3'd0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flush_o = (state == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt    <= 3'd0;
      redirect_o   <= 1'b0;
      target_o     <= 32'd0;
      illegal_br_o <= 1'b0;
      br_cnt_o     <= '0;
      taken_cnt_o  <= '0;
    end else begin
      redirect_o   <= take;
      illegal_br_o <= br_acc & cond_illegal;
      if (take) begin
        target_o  <= next_target;
        flush_cnt <= FLUSH_LOAD;
      end else if (state == ST_FLUSH && flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end
      // Statistics saturate rather than wrap
      if (br_acc && br_cnt_o != {CNT_W{1'b1}}) begin
        br_cnt_o <= br_cnt_o + 1'b1;
      end
      if (br_taken && taken_cnt_o != {CNT_W{1'b1}}) begin
        taken_cnt_o <= taken_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prv32_branch_resolve.sv
// Directed bench for prv32_branch_resolve; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_prv32_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_valid_i = 1'b0, jal_i = 1'b0, jalr_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic        cf_i = 1'b0, zf_i = 1'b0, vf_i = 1'b0, sf_i = 1'b0;
  logic [31:0] pc_i = '0, imm_i = '0, alu_r_i = '0;

  logic        redirect_o, flush_o, illegal_br_o;
  logic [31:0] target_o, br_cnt_o, taken_cnt_o;
  logic        s_redirect, s_flush, s_illegal;
  logic [31:0] s_target;
  logic [3:0]  s_br_cnt, s_taken_cnt;

  int totalChecks = 0;
  int badChecks   = 0;

  always #5 clk = ~clk;

  prv32_branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .br_valid_i(br_valid_i), .jal_i(jal_i), .jalr_i(jalr_i), .funct3_i(funct3_i),
    .cf_i(cf_i), .zf_i(zf_i), .vf_i(vf_i), .sf_i(sf_i),
    .pc_i(pc_i), .imm_i(imm_i), .alu_r_i(alu_r_i),
    .redirect_o(redirect_o), .target_o(target_o), .flush_o(flush_o),
    .illegal_br_o(illegal_br_o), .br_cnt_o(br_cnt_o), .taken_cnt_o(taken_cnt_o)
  );

  prv32_branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .br_valid_i(br_valid_i), .jal_i(jal_i), .jalr_i(jalr_i), .funct3_i(funct3_i),
    .cf_i(cf_i), .zf_i(zf_i), .vf_i(vf_i), .sf_i(sf_i),
    .pc_i(pc_i), .imm_i(imm_i), .alu_r_i(alu_r_i),
    .redirect_o(s_redirect), .target_o(s_target), .flush_o(s_flush),
    .illegal_br_o(s_illegal), .br_cnt_o(s_br_cnt), .taken_cnt_o(s_taken_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one EX instruction; flags come from a reference SUB of a-b
  task automatic applyStimulus(input logic brv, input logic jal, input logic jalr,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alur);
    logic [31:0] diff;
    diff       = a - b;
    br_valid_i = brv;
    jal_i      = jal;
    jalr_i     = jalr;
    funct3_i   = f3;
    cf_i       = (a >= b);
    zf_i       = (a == b);
    sf_i       = diff[31];
    vf_i       = (a[31] != b[31]) && (diff[31] != a[31]);
    pc_i       = pc;
    imm_i      = imm;
    alu_r_i    = alur;
  endtask

  task automatic clearInputs();
    br_valid_i = 1'b0;
    jal_i      = 1'b0;
    jalr_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    checkOutput("rst_redirect", {31'd0, redirect_o}, 32'd0);
    checkOutput("rst_target", target_o, 32'd0);
    checkOutput("rst_flush", {31'd0, flush_o}, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal_br_o}, 32'd0);
    checkOutput("rst_br_cnt", br_cnt_o, 32'd0);
    checkOutput("rst_taken_cnt", taken_cnt_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // BEQ 5,5 taken
    applyStimulus(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 32'd0);
    tick();
    clearInputs();
    checkOutput("beq_redirect", {31'd0, redirect_o}, 32'd1);
    checkOutput("beq_target", target_o, 32'h120);
    checkOutput("beq_flush1", {31'd0, flush_o}, 32'd1);
    checkOutput("beq_br_cnt", br_cnt_o, 32'd1);
    checkOutput("beq_taken_cnt", taken_cnt_o, 32'd1);
    tick();
    checkOutput("beq_pulse_end", {31'd0, redirect_o}, 32'd0);
    checkOutput("beq_flush2", {31'd0, flush_o}, 32'd1);
    tick();
    checkOutput("beq_flush_end", {31'd0, flush_o}, 32'd0);

    // BLTU 1 < 0xFFFFFFFF taken, negative immediate
    applyStimulus(1, 0, 0, 3'b110, 32'd1, 32'hFFFF_FFFF, 32'h200, 32'hFFFF_FFF8, 32'd0);
    tick();
    clearInputs();
    checkOutput("bltu_redirect", {31'd0, redirect_o}, 32'd1);
    checkOutput("bltu_target", target_o, 32'h1F8);
    tick();
    tick();
    // BGE -1 >= 1 not taken
    applyStimulus(1, 0, 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 32'd0);
    tick();
    clearInputs();
    checkOutput("bge_redirect", {31'd0, redirect_o}, 32'd0);
    checkOutput("bge_flush", {31'd0, flush_o}, 32'd0);
    checkOutput("bge_target_hold", target_o, 32'h1F8);
    checkOutput("bge_br_cnt", br_cnt_o, 32'd3);
    checkOutput("bge_taken_cnt", taken_cnt_o, 32'd2);

    // JALR clears bit 0; wrong-path branch during flush is ignored
    applyStimulus(0, 0, 1, 3'b000, 32'd0, 32'd0, 32'h400, 32'h0, 32'h0000_1235);
    tick();
    checkOutput("jalr_redirect", {31'd0, redirect_o}, 32'd1);
    checkOutput("jalr_target", target_o, 32'h1234);
    applyStimulus(1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h500, 32'h10, 32'd0);
    tick();
    checkOutput("wp_redirect1", {31'd0, redirect_o}, 32'd0);
    tick();
    checkOutput("wp_redirect2", {31'd0, redirect_o}, 32'd0);
    checkOutput("wp_br_cnt", br_cnt_o, 32'd3);
    checkOutput("wp_taken_cnt", taken_cnt_o, 32'd2);
    checkOutput("wp_flush_end", {31'd0, flush_o}, 32'd0);

    // Back-to-back: JAL in the first IDLE cycle after a flush
    applyStimulus(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h600, 32'h10, 32'd0);
    tick();
    clearInputs();
    checkOutput("b2b_redirect", {31'd0, redirect_o}, 32'd1);
    checkOutput("b2b_target", target_o, 32'h610);
    checkOutput("b2b_flush", {31'd0, flush_o}, 32'd1);
    checkOutput("b2b_br_cnt", br_cnt_o, 32'd3);
    tick();
    tick();

    // Reserved funct3
    applyStimulus(1, 0, 0, 3'b010, 32'd5, 32'd5, 32'h700, 32'h20, 32'd0);
    tick();
    clearInputs();
    checkOutput("ill_pulse", {31'd0, illegal_br_o}, 32'd1);
    checkOutput("ill_redirect", {31'd0, redirect_o}, 32'd0);
    checkOutput("ill_flush", {31'd0, flush_o}, 32'd0);
    checkOutput("ill_br_cnt", br_cnt_o, 32'd4);
    checkOutput("ill_taken_cnt", taken_cnt_o, 32'd2);
    tick();
    checkOutput("ill_pulse_end", {31'd0, illegal_br_o}, 32'd0);

    // Stalled BNE 3!=4 held until stall drops
    stall_i = 1'b1;
    applyStimulus(1, 0, 0, 3'b001, 32'd3, 32'd4, 32'h800, 32'h40, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_redirect", {31'd0, redirect_o}, 32'd0);
      checkOutput("stall_br_cnt", br_cnt_o, 32'd4);
    end
    stall_i = 1'b0;
    tick();
    clearInputs();
    checkOutput("bne_redirect", {31'd0, redirect_o}, 32'd1);
    checkOutput("bne_target", target_o, 32'h840);
    checkOutput("bne_br_cnt", br_cnt_o, 32'd5);
    checkOutput("bne_taken_cnt", taken_cnt_o, 32'd3);
    tick();
    tick();

    // Taken JAL then async reset inside the flush
    applyStimulus(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h900, 32'h4, 32'd0);
    tick();
    clearInputs();
    checkOutput("jal_redirect", {31'd0, redirect_o}, 32'd1);
    checkOutput("jal_target", target_o, 32'h904);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_redirect", {31'd0, redirect_o}, 32'd0);
    checkOutput("arst_target", target_o, 32'd0);
    checkOutput("arst_flush", {31'd0, flush_o}, 32'd0);
    checkOutput("arst_br_cnt", br_cnt_o, 32'd0);
    checkOutput("arst_taken_cnt", taken_cnt_o, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_flush", {31'd0, flush_o}, 32'd0);

    // Taken BGEU loop: 32-bit counters keep counting, 4-bit ones stick at 15
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 3'b111, 32'd9, 32'd2, 32'h1000, 32'h8, 32'd0);
      tick();
      clearInputs();
      if (i == 0) begin
        checkOutput("post_rst_redirect", {31'd0, redirect_o}, 32'd1);
        checkOutput("post_rst_target", target_o, 32'h1008);
      end
      if (i == 14) begin
        checkOutput("sat_br_at15", {28'd0, s_br_cnt}, 32'd15);
      end
      tick();
      tick();
    end
    checkOutput("loop_br_cnt", br_cnt_o, 32'd20);
    checkOutput("loop_taken_cnt", taken_cnt_o, 32'd20);
    checkOutput("sat_br_cnt", {28'd0, s_br_cnt}, 32'd15);
    checkOutput("sat_taken_cnt", {28'd0, s_taken_cnt}, 32'd15);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
